serial_subtractor: RTL and testbench

//  Bit-serial N-bit subtractor computing diff = a - b - borrow_in, one bit per clock, LSB first.

---
 rtl/arith_pkg.sv | 10 +
 rtl/full_subtractor_cell.sv | 13 +
 rtl/serial_subtractor.sv | 125 ++++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding.
package arith_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: diff = a - b - borrow_in, with borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready on both sides.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             borrow_out,
    output logic             overflow
`else
    output logic             borrow_out
`endif
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam int unsigned      RES_W    = WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [RES_W-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_br;
    logic               w_accept;
    logic               w_last;
    logic               w_d;
    logic               w_br_nxt;
    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_LAST);

    full_subtractor_cell u_cell (
        .a          (r_a[0]),
        .b          (r_b[0]),
        .borrow_in  (r_br),
        .diff       (w_d),
        .borrow_out (w_br_nxt)
    );

    // State register, handshake outputs registered alongside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            in_ready  <= w_in_ready_nxt;
            out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = RUN;
            RUN:     if (r_cnt == CNT_LAST) w_state_nxt = DONE;
            DONE:    if (out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = (w_state_nxt == IDLE);
        w_out_valid_nxt = (w_state_nxt == DONE);
    end

    // Operand shifters, borrow flop, counter; result published only on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= borrow_in;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= RES_W'({w_d, r_res} >> 1);
            r_br  <= w_br_nxt;
            if (w_last) begin
                diff       <= {w_d, r_res};
                borrow_out <= w_br_nxt;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // On the last bit r_a[0]/r_b[0] hold the original operand MSBs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (w_last) begin
            overflow <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): arithmetic model plus per-cycle compare.
module tb_serial_subtractor;

    localparam int unsigned W    = 8;
    localparam int          SMAX = (1 << (W - 1)) - 1;
    localparam int          SMIN = -SMAX - 1;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mph_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf_dut;
    logic         chk_en;

    int total;
    int bad;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic overflow;
    assign ovf_dut = overflow;
`else
    assign ovf_dut = 1'b0;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .borrow_out (borrow_out),
        .overflow   (overflow)
`else
        .borrow_out (borrow_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Plain integer arithmetic: unsigned for diff/borrow, signed range for overflow
    function automatic res_t model_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        res_t r;
        int   u;
        int   s;
        u    = int'(x) - int'(y) - int'(bi);
        s    = int'($signed(x)) - int'($signed(y)) - int'(bi);
        r.d  = W'(u);
        r.bo = (u < 0);
        r.ov = (s < SMIN) || (s > SMAX);
        return r;
    endfunction

    mph_t m_ph;
    int   m_edges;
    res_t m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph    <= M_IDLE;
            m_edges <= 0;
        end else begin
            case (m_ph)
                M_IDLE: if (in_valid) begin
                    m_ph    <= M_RUN;
                    m_edges <= 0;
                    m_res   <= model_sub(a, b, borrow_in);
                end
                M_RUN: begin
                    if (m_edges + 1 == int'(W)) m_ph <= M_DONE;
                    m_edges <= m_edges + 1;
                end
                M_DONE: if (out_ready) m_ph <= M_IDLE;
                default: m_ph <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready", 32'(in_ready), 32'(m_ph == M_IDLE));
            chk("out_valid", 32'(out_valid), 32'(m_ph == M_DONE));
            if (m_ph == M_DONE) begin
                chk("diff", 32'(diff), 32'(m_res.d));
                chk("borrow_out", 32'(borrow_out), 32'(m_res.bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("overflow", 32'(ovf_dut), 32'(m_res.ov));
`endif
            end
        end
    end

    // One transaction; inputs change 1 time unit after the rising edge
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbi,
                          input int hold, input logic hold_iv, output res_t got);
        int   n;
        int   lat;
        logic was_ready;
        @(posedge clk); #1;
        a = ta; b = tb_v; borrow_in = tbi; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        do begin
            was_ready = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!was_ready && n < 100);
        if (!was_ready) fail_now("accept");
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(W));
        in_valid = hold_iv;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        got       = '{d: diff, bo: borrow_out, ov: ovf_dut};
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    task automatic check_lit(input string name, input res_t got, input logic [W-1:0] d,
                             input logic bo, input logic ov);
        chk({name, "_diff"}, 32'(got.d), 32'(d));
        chk({name, "_bout"}, 32'(got.bo), 32'(bo));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({name, "_ovf"}, 32'(got.ov), 32'(ov));
`else
        if (ov === 1'bx) $display("unexpected x in literal table for %s", name);
`endif
    endtask

    initial begin
        res_t got;
        total = 0; bad = 0; chk_en = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(borrow_out), 32'd0);
        chk("rst_ovf", 32'(ovf_dut), 32'd0);

        run_op(8'h05, 8'h03, 1'b0, 0, 1'b0, got); check_lit("t05_03", got, 8'h02, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 1, 1'b0, got); check_lit("t00_01", got, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 0, 1'b0, got); check_lit("t80_01", got, 8'h7F, 1'b0, 1'b1);
        run_op(8'h10, 8'h10, 1'b1, 2, 1'b0, got); check_lit("t10_10", got, 8'hFF, 1'b1, 1'b0);
        run_op(8'hC3, 8'h5A, 1'b0, 5, 1'b1, got); check_lit("hold5", got, 8'h69, 1'b0, 1'b1);

        // Reset while bit 3 is being processed
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h0F; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (W + 2) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(out_valid), 32'd0);
        run_op(8'h2A, 8'h0F, 1'b0, 0, 1'b0, got); check_lit("after_rst", got, 8'h1B, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), got);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
